serial_word_tx: RTL and testbench
=================================

Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter; the sending end of the 1-bit capture link.
- Frame format: 64-bit word, one bit per bit-period, LSB first.
- Bit k of the word goes out while sbit_idx = k, so the receiver's 6-bit index counter lands it in ri[k].
- Loaded byte-wide from the 8-bit pin bus into a holding buffer. The buffer is double-buffered against the shifter, so frames stream back-to-back with no gap.

Parameters:
- BIT_DIV, default 1: clock cycles per transmitted bit. Legal range 1..255; 0 is illegal. The divider counter is 8 bits.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- wr_data  input  8  byte to load into the holding buffer
- wr_valid  input  1  wr_data is valid this cycle
- wr_ready  output  1  holding buffer can accept a byte
- abort  input  1  synchronous: drop the partial/held word and the current frame
- sdo  output  1  serial data out, registered
- sframe  output  1  high for the whole bit-period of bit 0 of each frame
- sbit_idx  output  6  index of the bit currently on sdo
- busy  output  1  a frame is being transmitted
- done  output  1  one-cycle pulse after bit 63 of a frame completes

Behaviour:
- Reset (async, rst=1) clears:
  - outputs: sdo=0, sframe=0, sbit_idx=0, busy=0, done=0, wr_ready=1;
  - internal state: byte_ptr=0, hold_full=0, div_cnt=0, shifter=0, holding buffer=0.
- Load:
  - A byte is accepted on an edge where wr_valid && wr_ready.
  - The byte is written to hold[8*byte_ptr +: 8], then byte_ptr increments.
  - Accepting the byte with byte_ptr=7 wraps byte_ptr to 0 and sets hold_full=1.
  - wr_ready = !hold_full (combinational from the register).
  - A partial word persists indefinitely until completed or aborted.
- State machine: IDLE, SEND.
- IDLE, hold_full=1 at an edge:
  - shifter<=hold, hold_full<=0, sbit_idx<=0;
  - sdo<=hold[0], sframe<=1, busy<=1, div_cnt<=0;
  - go to SEND.
  - Latency: byte 7 accepted at edge N → bit 0 on sdo after edge N+1.
- SEND, per-bit timing:
  - div_cnt counts 0..BIT_DIV-1. sdo, sbit_idx and sframe are held for BIT_DIV cycles.
  - At div_cnt=BIT_DIV-1 with sbit_idx<63: sbit_idx++, sdo<=shifter[sbit_idx+1], sframe<=0, div_cnt<=0.
- SEND, end of frame (div_cnt=BIT_DIV-1 with sbit_idx=63):
  - done<=1 for one cycle.
  - If hold_full=1: load the shifter exactly as in IDLE, so bit 0 of the next frame follows with no gap. Stay in SEND, busy stays 1.
  - Else: go to IDLE with busy<=0, sdo<=0, sframe<=0, sbit_idx<=0.
- While sending, new bytes may load freely while !hold_full.
- A write cannot coincide with a transfer edge, because wr_ready=0 whenever hold_full=1.
- abort=1 at an edge:
  - clears byte_ptr, hold_full, busy, sdo, sframe, sbit_idx and div_cnt; state goes to IDLE; done is not pulsed.
  - abort overrides a simultaneous write: the byte is discarded and wr_ready is 1 after the edge.
- With BIT_DIV=1, one bit per clock; a 64-bit frame occupies exactly 64 cycles.
- Mid-frame rst: all state is cleared asynchronously; the frame is lost.

Test Plan:
- Single frame, BIT_DIV=1:
  - Stimulus: load bytes 0x01,0x23,0x45,0x67,0x89,0xAB,0xCD,0xEF (word 0xEFCDAB8967452301).
  - Required: sdo sequence equals bits 0..63 LSB-first; sframe high only at sbit_idx=0; busy high exactly 64 cycles; done pulses once after bit 63; bit 0 appears 1 cycle after byte 7 is accepted.
- Back-to-back streaming:
  - Stimulus: load word A, then word B during A's transmission.
  - Required: B's bit 0 directly follows A's bit 63 (no gap); sframe pulses at cycle 0 and 64; done pulses at both frame ends; busy never drops between frames.
- BIT_DIV=3:
  - Stimulus: send word 0x0000000000000005.
  - Required: each bit held 3 cycles, 192 busy cycles; sdo is high in cycles 0-2 and 6-8 of the frame, low elsewhere.
- Backpressure:
  - Stimulus: hold_full set while frame A is sending; drive wr_valid=1 continuously.
  - Required: wr_ready=0 until A completes and B transfers; no byte is lost or duplicated (check B's content bit-exact).
- Abort:
  - Stimulus (a): load 3 bytes, then abort. Required: byte_ptr=0, and the next 8 bytes form the frame exactly.
  - Stimulus (b): abort at sbit_idx=20. Required: sdo=0, busy=0, done not pulsed.
- Async reset mid-frame:
  - Stimulus: assert rst at sbit_idx=40 between clock edges.
  - Required: all outputs reach their reset values immediately; wr_ready=1.

Source files
------------

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: bytes fill a 64-bit holding buffer,
// which is handed to a shifter and sent LSB first, one bit per BIT_DIV cycles.
// The holding buffer refills while the shifter sends, so frames stream without gaps.
module serial_word_tx #(
  parameter int unsigned BIT_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       abort,
  output logic       sdo,
  output logic       sframe,
  output logic [5:0] sbit_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] DivLast = 8'(BIT_DIV - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic [63:0] hold_q, hold_d;
  logic [2:0]  byte_ptr_q, byte_ptr_d;
  logic        hold_full_q, hold_full_d;
  // Bit 0 goes straight from the holding buffer to sdo, so only bits 63:1 are kept.
  logic [63:1] shifter_q, shifter_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [5:0]  sbit_idx_q, sbit_idx_d;
  logic        sdo_q, sdo_d;
  logic        sframe_q, sframe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        start_frame;
  logic [5:0]  idx_nxt;

  assign wr_ready = !hold_full_q;
  assign sdo      = sdo_q;
  assign sframe   = sframe_q;
  assign sbit_idx = sbit_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign idx_nxt  = sbit_idx_q + 6'd1;

  // Next-state: byte loading, bit timing, frame hand-off and abort.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    byte_ptr_d  = byte_ptr_q;
    hold_full_d = hold_full_q;
    shifter_d   = shifter_q;
    div_cnt_d   = div_cnt_q;
    sbit_idx_d  = sbit_idx_q;
    sdo_d       = sdo_q;
    sframe_d    = sframe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    start_frame = 1'b0;

    case (state_q)
      StIdle: begin
        if (hold_full_q) start_frame = 1'b1;
      end
      StSend: begin
        if (div_cnt_q == DivLast) begin
          if (sbit_idx_q != 6'd63) begin
            sbit_idx_d = idx_nxt;
            sdo_d      = shifter_q[idx_nxt];
            sframe_d   = 1'b0;
            div_cnt_d  = 8'd0;
          end else begin
            done_d = 1'b1;
            if (hold_full_q) begin
              start_frame = 1'b1;
            end else begin
              state_d    = StIdle;
              busy_d     = 1'b0;
              sdo_d      = 1'b0;
              sframe_d   = 1'b0;
              sbit_idx_d = 6'd0;
              div_cnt_d  = 8'd0;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_frame) begin
      shifter_d   = hold_q[63:1];
      hold_full_d = 1'b0;
      sbit_idx_d  = 6'd0;
      sdo_d       = hold_q[0];
      sframe_d    = 1'b1;
      busy_d      = 1'b1;
      div_cnt_d   = 8'd0;
      state_d     = StSend;
    end

    // A write never coincides with start_frame: both depend on hold_full_q, oppositely.
    if (wr_valid && !hold_full_q) begin
      hold_d[{byte_ptr_q, 3'b000} +: 8] = wr_data;
      byte_ptr_d = byte_ptr_q + 3'd1;
      if (byte_ptr_q == 3'd7) hold_full_d = 1'b1;
    end

    if (abort) begin
      state_d     = StIdle;
      byte_ptr_d  = 3'd0;
      hold_full_d = 1'b0;
      busy_d      = 1'b0;
      sdo_d       = 1'b0;
      sframe_d    = 1'b0;
      sbit_idx_d  = 6'd0;
      div_cnt_d   = 8'd0;
      done_d      = 1'b0;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_q      <= 64'd0;
      byte_ptr_q  <= 3'd0;
      hold_full_q <= 1'b0;
      shifter_q   <= '0;
      div_cnt_q   <= 8'd0;
      sbit_idx_q  <= 6'd0;
      sdo_q       <= 1'b0;
      sframe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      byte_ptr_q  <= byte_ptr_d;
      hold_full_q <= hold_full_d;
      shifter_q   <= shifter_d;
      div_cnt_q   <= div_cnt_d;
      sbit_idx_q  <= sbit_idx_d;
      sdo_q       <= sdo_d;
      sframe_q    <= sframe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: one instance with BIT_DIV=1, one with BIT_DIV=3.
// A time-based frame model predicts every output each cycle.
module tb_serial_word_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data [2];
  logic [1:0] wr_valid, abort, wr_ready, sdo, sframe, busy, done;
  logic [5:0] sbit_idx [2];

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] WordA = 64'hEFCDAB8967452301;
  localparam logic [63:0] WordB = 64'h0123456789ABCDEF;
  localparam logic [63:0] WordC = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] WordD = 64'h5A5AF00F3C3C9669;

  always #5 clk = ~clk;

  serial_word_tx #(.BIT_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_data(wr_data[0]), .wr_valid(wr_valid[0]),
    .wr_ready(wr_ready[0]), .abort(abort[0]), .sdo(sdo[0]), .sframe(sframe[0]),
    .sbit_idx(sbit_idx[0]), .busy(busy[0]), .done(done[0])
  );

  serial_word_tx #(.BIT_DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .wr_data(wr_data[1]), .wr_valid(wr_valid[1]),
    .wr_ready(wr_ready[1]), .abort(abort[1]), .sdo(sdo[1]), .sframe(sframe[1]),
    .sbit_idx(sbit_idx[1]), .busy(busy[1]), .done(done[1])
  );

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is (word, start edge); outputs follow from elapsed edges.
  int          cyc;
  logic [63:0] m_hold [2];
  logic [63:0] m_word [2];
  int          m_ptr [2];
  int          m_start [2];
  bit          m_full [2];
  bit          m_active [2];
  bit          m_done [2];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
        m_hold[i] = '0; m_word[i] = '0; m_ptr[i] = 0; m_start[i] = 0;
        m_full[i] = 0; m_active[i] = 0; m_done[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        bit full_pre;
        full_pre = m_full[i];
        m_done[i] = 0;
        if (abort[i]) begin
          m_ptr[i] = 0; m_full[i] = 0; m_active[i] = 0;
        end else begin
          if (m_active[i] && (cyc - m_start[i] == 64 * div_of(i))) begin
            m_done[i] = 1; m_active[i] = 0;
          end
          if (!m_active[i] && full_pre) begin
            m_word[i] = m_hold[i]; m_start[i] = cyc; m_active[i] = 1; m_full[i] = 0;
          end
          if (wr_valid[i] && !full_pre) begin
            m_hold[i][8*m_ptr[i] +: 8] = wr_data[i];
            if (m_ptr[i] == 7) begin
              m_ptr[i] = 0; m_full[i] = 1;
            end else begin
              m_ptr[i]++;
            end
          end
        end
      end
    end
  end

  // Recorded traffic, per instance.
  bit cap0 [$];
  bit cap1 [$];
  int busy_cnt [2];
  int fr_cnt [2];
  int done_cnt [2];
  int first_busy [2];
  int last_busy [2];

  // Per-cycle comparison against the model, then recording.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        int       idx;
        logic     e_sdo, e_fr, e_busy;
        logic [5:0] e_idx;
        e_sdo = 0; e_fr = 0; e_busy = 0; e_idx = 0;
        if (m_active[i]) begin
          idx = (cyc - m_start[i]) / div_of(i);
          e_sdo = m_word[i][idx]; e_fr = (idx == 0); e_busy = 1; e_idx = 6'(idx);
        end
        check($sformatf("dut%0d sdo", i), 64'(sdo[i]), 64'(e_sdo));
        check($sformatf("dut%0d sframe", i), 64'(sframe[i]), 64'(e_fr));
        check($sformatf("dut%0d sbit_idx", i), 64'(sbit_idx[i]), 64'(e_idx));
        check($sformatf("dut%0d busy", i), 64'(busy[i]), 64'(e_busy));
        check($sformatf("dut%0d done", i), 64'(done[i]), 64'(m_done[i]));
        check($sformatf("dut%0d wr_ready", i), 64'(wr_ready[i]), 64'(!m_full[i]));
        if (busy[i]) begin
          if (i == 0) cap0.push_back(sdo[i]); else cap1.push_back(sdo[i]);
          busy_cnt[i]++;
          if (first_busy[i] < 0) first_busy[i] = cyc;
          last_busy[i] = cyc;
        end
        if (sframe[i]) fr_cnt[i]++;
        if (done[i]) done_cnt[i]++;
      end
    end
  end

  task automatic clear_rec();
    @(posedge clk); #1;
    cap0.delete(); cap1.delete();
    for (int i = 0; i < 2; i++) begin
      busy_cnt[i] = 0; fr_cnt[i] = 0; done_cnt[i] = 0; first_busy[i] = -1; last_busy[i] = -1;
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] frame_word(input int i, input int f);
    logic [63:0] w;
    int          p;
    w = '0;
    for (int k = 0; k < 64; k++) begin
      p = (f * 64 + k) * div_of(i);
      if (i == 0) begin if (p < cap0.size()) w[k] = cap0[p]; end
      else begin if (p < cap1.size()) w[k] = cap1[p]; end
    end
    return w;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge, valid still high.
  task automatic write_byte(input int i, input logic [7:0] b, output int waited);
    bit acc;
    wr_data[i] = b; wr_valid[i] = 1'b1; waited = 0;
    do begin
      acc = wr_ready[i];
      @(negedge clk);
      if (!acc) waited++;
    end while (!acc && waited < 2000);
    if (!acc) check("write_byte timeout", 64'(waited), 64'd0);
  endtask

  task automatic wr_word(input int i, input logic [63:0] w, output int first_wait);
    int wt;
    write_byte(i, w[7:0], first_wait);
    for (int b = 1; b < 8; b++) write_byte(i, w[8*b +: 8], wt);
    wr_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int bound);
    int n;
    n = 0;
    while (busy[i] && n < bound) begin @(negedge clk); n++; end
    check("wait_idle timeout", 64'(busy[i]), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idx(input int i, input logic [5:0] v);
    int n;
    n = 0;
    while (sbit_idx[i] != v && n < 1000) begin @(negedge clk); n++; end
    check("wait_idx timeout", 64'(sbit_idx[i]), 64'(v));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected earlier", $time);
    $fatal(1);
  end

  initial begin
    int fw;
    int bad;
    for (int i = 0; i < 2; i++) begin
      wr_data[i] = 8'd0; first_busy[i] = -1; last_busy[i] = -1;
    end
    wr_valid = '0; abort = '0;
    repeat (3) @(negedge clk);
    check("reset sdo", 64'(sdo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset sframe", 64'(sframe), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset wr_ready", 64'(wr_ready), 64'd3);
    check("reset sbit_idx", 64'(sbit_idx[0]), 64'd0);
    rst = 1'b0;
    clear_rec();

    // Single frame, one bit per clock.
    wr_word(0, WordA, fw);
    check("latency busy before", 64'(busy[0]), 64'd0);
    @(negedge clk);
    check("latency sframe", 64'(sframe[0]), 64'd1);
    check("latency sdo bit0", 64'(sdo[0]), 64'd1);
    wait_idle(0, 200);
    check("single frame word", frame_word(0, 0), WordA);
    check("single busy cycles", 64'(busy_cnt[0]), 64'd64);
    check("single done pulses", 64'(done_cnt[0]), 64'd1);
    check("single sframe cycles", 64'(fr_cnt[0]), 64'd1);

    // Back-to-back streaming with backpressure on the third word.
    clear_rec();
    wr_word(0, WordA, fw);
    wr_word(0, WordB, fw);
    wr_word(0, WordC, fw);
    check("backpressure stalled", 64'(fw >= 40), 64'd1);
    @(negedge clk);
    wait_idle(0, 400);
    check("stream word A", frame_word(0, 0), WordA);
    check("stream word B", frame_word(0, 1), WordB);
    check("stream word C", frame_word(0, 2), WordC);
    check("stream busy cycles", 64'(busy_cnt[0]), 64'd192);
    check("stream busy no gap", 64'(last_busy[0] - first_busy[0] + 1), 64'd192);
    check("stream done pulses", 64'(done_cnt[0]), 64'd3);
    check("stream sframe cycles", 64'(fr_cnt[0]), 64'd3);

    // Three clocks per bit.
    clear_rec();
    wr_word(1, 64'h5, fw);
    @(negedge clk);
    wait_idle(1, 800);
    check("div3 busy cycles", 64'(busy_cnt[1]), 64'd192);
    check("div3 captured", 64'(cap1.size()), 64'd192);
    bad = 0;
    for (int c = 0; c < cap1.size(); c++)
      if (cap1[c] != ((c <= 2) || (c >= 6 && c <= 8))) bad++;
    check("div3 sdo pattern errors", 64'(bad), 64'd0);
    check("div3 done pulses", 64'(done_cnt[1]), 64'd1);
    check("div3 sframe cycles", 64'(fr_cnt[1]), 64'd3);

    // Abort a partial word, with a simultaneous write that must be dropped.
    clear_rec();
    write_byte(0, 8'h11, fw);
    write_byte(0, 8'h22, fw);
    write_byte(0, 8'h33, fw);
    wr_data[0] = 8'hFF; abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0; wr_valid[0] = 1'b0;
    check("abort partial wr_ready", 64'(wr_ready[0]), 64'd1);
    wr_word(0, WordD, fw);
    @(negedge clk);
    wait_idle(0, 200);
    check("abort partial next word", frame_word(0, 0), WordD);
    check("abort partial captured", 64'(cap0.size()), 64'd64);

    // Abort in mid-frame.
    clear_rec();
    wr_word(0, WordA, fw);
    wait_idx(0, 6'd20);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("abort frame sdo", 64'(sdo[0]), 64'd0);
    check("abort frame busy", 64'(busy[0]), 64'd0);
    repeat (70) @(negedge clk);
    check("abort frame no done", 64'(done_cnt[0]), 64'd0);

    // Asynchronous reset in mid-frame.
    wr_word(0, WordB, fw);
    wait_idx(0, 6'd40);
    #2 rst = 1'b1;
    #1;
    check("async rst sdo", 64'(sdo[0]), 64'd0);
    check("async rst busy", 64'(busy[0]), 64'd0);
    check("async rst sframe", 64'(sframe[0]), 64'd0);
    check("async rst sbit_idx", 64'(sbit_idx[0]), 64'd0);
    check("async rst done", 64'(done[0]), 64'd0);
    check("async rst wr_ready", 64'(wr_ready[0]), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    clear_rec();
    wr_word(0, WordC, fw);
    @(negedge clk);
    wait_idle(0, 200);
    check("post reset word", frame_word(0, 0), WordC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
